// File: rtl/uniform_coeff_sampler.sv
// Rejection sampler: splits PRNG words into COEF_W-bit candidates, keeps those below q,
// buffers accepted coefficients in a small multi-push show-ahead FIFO with a per-entry last flag.
module uniform_coeff_sampler #(
  parameter int RAND_W     = 64,
  parameter int COEF_W     = 30,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_coeffs,
  input  logic [COEF_W-1:0] q,
  input  logic [RAND_W-1:0] rand_in,
  input  logic              rand_valid,
  output logic              rand_ready,
  output logic [COEF_W-1:0] coef_out,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              coef_last,
  output logic              busy,
  output logic              done,
  output logic [15:0]       reject_cnt
);

  localparam int LANES = RAND_W / COEF_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [COEF_W-1:0] q_r;
  logic [CNT_W-1:0]  num_r;
  logic [CNT_W-1:0]  prod_cnt;

  logic [COEF_W-1:0] mem_coef [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;

  logic              fifo_empty;
  logic [OCC_W-1:0]  free_slots;
  logic              take;
  logic              pop;

  logic [COEF_W-1:0] cand      [LANES];
  logic              lane_push [LANES];
  logic              lane_last [LANES];
  logic [PTR_W-1:0]  lane_addr [LANES];
  logic [CNT_W-1:0]  prod_next;
  logic [15:0]       reject_next;
  logic [OCC_W-1:0]  push_cnt;

  logic unused_bits;
  assign unused_bits = ^rand_in[RAND_W-1:LANES*COEF_W];

  assign fifo_empty = (occ == '0);
  assign free_slots = OCC_W'(FIFO_DEPTH) - occ;
  assign rand_ready = (state == S_RUN) && (free_slots >= OCC_W'(LANES));
  assign take       = rand_valid && rand_ready;
  assign coef_valid = !fifo_empty;
  assign pop        = coef_valid && coef_ready;
  assign coef_out   = fifo_empty ? '0 : mem_coef[rd_ptr];
  assign coef_last  = !fifo_empty && mem_last[rd_ptr];
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  // Lanes are resolved in order so an early acceptance can use up the last slot of the job.
  always_comb begin
    prod_next   = prod_cnt;
    reject_next = reject_cnt;
    push_cnt    = '0;
    for (int i = 0; i < LANES; i++) begin
      cand[i]      = rand_in[i*COEF_W +: COEF_W];
      lane_push[i] = 1'b0;
      lane_last[i] = 1'b0;
      lane_addr[i] = wr_ptr + PTR_W'(push_cnt);
      if (take && (prod_next < num_r)) begin
        if (cand[i] < q_r) begin
          lane_push[i] = 1'b1;
          prod_next    = prod_next + CNT_W'(1);
          lane_last[i] = (prod_next == num_r);
          push_cnt     = push_cnt + OCC_W'(1);
        end else if (reject_next != 16'hFFFF) begin
          reject_next = reject_next + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_coef[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_push[i]) begin
          mem_coef[lane_addr[i]] <= cand[i];
          mem_last[lane_addr[i]] <= lane_last[i];
        end
      end
      wr_ptr <= wr_ptr + PTR_W'(push_cnt);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      occ <= occ + push_cnt - (pop ? OCC_W'(1) : OCC_W'(0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      q_r        <= '0;
      num_r      <= '0;
      prod_cnt   <= '0;
      reject_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            q_r        <= q;
            num_r      <= num_coeffs;
            prod_cnt   <= '0;
            reject_cnt <= '0;
            state      <= (num_coeffs != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          prod_cnt   <= prod_next;
          reject_cnt <= reject_next;
          if (take && (prod_next == num_r)) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_empty) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uniform_coeff_sampler.sv
// Directed and randomized checks of uniform_coeff_sampler against hand-computed values and a queue model.
module tb_uniform_coeff_sampler;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_coeffs;
  logic [29:0] q;
  logic [63:0] rand_in;
  logic        rand_valid;
  logic        rand_ready;
  logic [29:0] coef_out;
  logic        coef_valid;
  logic        coef_ready;
  logic        coef_last;
  logic        busy;
  logic        done;
  logic [15:0] reject_cnt;

  int n_chk;
  int n_bad;

  uniform_coeff_sampler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_coeffs (num_coeffs),
    .q          (q),
    .rand_in    (rand_in),
    .rand_valid (rand_valid),
    .rand_ready (rand_ready),
    .coef_out   (coef_out),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_last  (coef_last),
    .busy       (busy),
    .done       (done),
    .reject_cnt (reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [63:0] mkw(input logic [3:0] top, input logic [29:0] l1, input logic [29:0] l0);
    return {top, l1, l0};
  endfunction

  task automatic kick(input logic [15:0] n, input logic [29:0] qq);
    start      = 1'b1;
    num_coeffs = n;
    q          = qq;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && !done; i++) tick;
    chk("done_seen", done, 1);
    tick;
    chk("done_pulse", done, 0);
  endtask

  // random-phase model state
  logic [29:0] exp_q [$];
  logic        exp_l [$];
  int          exp_prod;
  int          exp_rej;
  int          popped;
  logic        prev_stall;
  logic [29:0] prev_out;
  logic        cr;
  logic        rv;
  logic [63:0] w;
  logic [29:0] ln;
  logic        seen_ready;

  initial begin
    n_chk = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; num_coeffs = '0; q = '0;
    rand_in = '0; rand_valid = 1'b0; coef_ready = 1'b0;
    tick; tick;
    chk("rst_ready", rand_ready, 0);
    chk("rst_valid", coef_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", coef_out, 0);
    chk("rst_rej", reject_cnt, 0);
    rst = 1'b0;
    tick;

    // Two accepted lanes from one word, exact cycle timing
    kick(16'd2, 30'd1000);
    chk("t1_busy", busy, 1);
    chk("t1_ready", rand_ready, 1);
    chk("t1_novalid", coef_valid, 0);
    rand_in = mkw(4'h0, 30'd999, 30'd5); rand_valid = 1'b1; coef_ready = 1'b1;
    tick;
    rand_valid = 1'b0;
    chk("t1_v0", coef_valid, 1);
    chk("t1_c0", coef_out, 5);
    chk("t1_l0", coef_last, 0);
    chk("t1_drain_ready", rand_ready, 0);
    tick;
    chk("t1_c1", coef_out, 999);
    chk("t1_l1", coef_last, 1);
    tick;
    chk("t1_empty", coef_valid, 0);
    chk("t1_notdone", done, 0);
    tick;
    chk("t1_done", done, 1);
    chk("t1_rej", reject_cnt, 0);
    tick;
    chk("t1_done_off", done, 0);
    chk("t1_idle", busy, 0);

    // Rejections and discarded top nibble
    kick(16'd2, 30'd1000);
    rand_in = mkw(4'h0, 30'd7, 30'd1000); rand_valid = 1'b1;
    tick;
    chk("t2_c0", coef_out, 7);
    chk("t2_l0", coef_last, 0);
    chk("t2_ready", rand_ready, 1);
    rand_in = mkw(4'hF, 30'd42, 30'h3FFFFFFF);
    tick;
    rand_valid = 1'b0;
    chk("t2_c1", coef_out, 42);
    chk("t2_l1", coef_last, 1);
    chk("t2_rej", reject_cnt, 2);
    wait_done(6);

    // Stalled output: fourth candidate dropped, hold while stalled
    coef_ready = 1'b0;
    kick(16'd3, 30'd1000);
    chk("t3_ready0", rand_ready, 1);
    rand_in = mkw(4'h0, 30'd11, 30'd10); rand_valid = 1'b1;
    tick;
    chk("t3_ready1", rand_ready, 1);
    chk("t3_head", coef_out, 10);
    rand_in = mkw(4'h0, 30'd13, 30'd12);
    tick;
    chk("t3_ready2", rand_ready, 0);
    chk("t3_busy", busy, 1);
    tick; tick;
    chk("t3_hold_v", coef_valid, 1);
    chk("t3_hold_c", coef_out, 10);
    rand_valid = 1'b0; coef_ready = 1'b1;
    chk("t3_c0", coef_out, 10);
    chk("t3_l0", coef_last, 0);
    tick;
    chk("t3_c1", coef_out, 11);
    chk("t3_l1", coef_last, 0);
    tick;
    chk("t3_c2", coef_out, 12);
    chk("t3_l2", coef_last, 1);
    tick;
    chk("t3_empty", coef_valid, 0);
    chk("t3_rej", reject_cnt, 0);
    wait_done(4);

    // Zero-length job
    kick(16'd0, 30'd1000);
    chk("t4_done", done, 1);
    chk("t4_ready", rand_ready, 0);
    chk("t4_valid", coef_valid, 0);
    tick;
    chk("t4_done_off", done, 0);
    chk("t4_idle", busy, 0);
    chk("t4_valid2", coef_valid, 0);

    // Start while busy is ignored
    kick(16'd2, 30'd1000);
    start = 1'b1; num_coeffs = 16'd5;
    tick;
    start = 1'b0;
    rand_in = mkw(4'h0, 30'd1, 30'd2); rand_valid = 1'b1;
    tick;
    rand_valid = 1'b0;
    chk("t5_num_kept", rand_ready, 0);
    chk("t5_c0", coef_out, 2);
    tick;
    chk("t5_c1", coef_out, 1);
    chk("t5_l1", coef_last, 1);
    wait_done(6);

    // Async reset mid-job
    coef_ready = 1'b0;
    kick(16'd4, 30'd1000);
    rand_in = mkw(4'h0, 30'd3, 30'd2000); rand_valid = 1'b1;
    tick;
    rand_valid = 1'b0;
    chk("t6_pre_rej", reject_cnt, 1);
    chk("t6_pre_v", coef_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_v", coef_valid, 0);
    chk("t6_rst_c", coef_out, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", rand_ready, 0);
    chk("t6_rst_rej", reject_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t6_no_done", done, 0);
    end
    rst = 1'b0;
    tick;
    chk("t6_no_done2", done, 0);
    coef_ready = 1'b1;
    kick(16'd1, 30'd1000);
    rand_in = mkw(4'h0, 30'd9, 30'd8); rand_valid = 1'b1;
    tick;
    rand_valid = 1'b0;
    chk("t6_c0", coef_out, 8);
    chk("t6_l0", coef_last, 1);
    chk("t6_rej", reject_cnt, 0);
    wait_done(6);

    // Randomized run against a queue model
    kick(16'd1700, 30'h3FFFFFFF);
    exp_prod = 0; exp_rej = 0; popped = 0; prev_stall = 1'b0; prev_out = '0;
    seen_ready = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      if (prev_stall) begin
        chk("rnd_stall_v", coef_valid, 1);
        chk("rnd_stall_c", coef_out, prev_out);
      end
      cr = ($urandom_range(0, 1) == 1);
      rv = ($urandom_range(0, 3) != 0);
      w[63:60] = 4'($urandom);
      for (int l = 0; l < 2; l++) begin
        ln = ($urandom_range(0, 7) == 0) ? 30'h3FFFFFFF : 30'($urandom);
        w[l*30 +: 30] = ln;
      end
      if (coef_valid && cr) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra", coef_valid, 0);
        end else begin
          chk("rnd_dat", coef_out, exp_q.pop_front());
          chk("rnd_last", coef_last, exp_l.pop_front());
          popped++;
        end
      end
      if (rv && rand_ready) begin
        for (int l = 0; l < 2; l++) begin
          ln = w[l*30 +: 30];
          if (exp_prod < 1700) begin
            if (ln < 30'h3FFFFFFF) begin
              exp_prod++;
              exp_q.push_back(ln);
              exp_l.push_back(exp_prod == 1700);
            end else if (exp_rej < 65535) begin
              exp_rej++;
            end
          end
        end
      end
      prev_stall = coef_valid && !cr;
      prev_out   = coef_out;
      coef_ready = cr;
      rand_valid = rv;
      rand_in    = w;
      tick;
    end
    rand_valid = 1'b0;
    chk("rnd_done", done, 1);
    chk("rnd_count", popped, 1700);
    chk("rnd_rej", reject_cnt, exp_rej);
    chk("rnd_left", exp_q.size(), 0);
    tick;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
